// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ_DEF = 4;

  // Width needed to encode requester indices plus the "no grant" code.
  function automatic int id_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Grant ID meaning "no grant" for the default requester count.
  localparam int GNT_NONE = NUM_REQ_DEF;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - rotated fixed-priority encoder: first set mask bit from base upward
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [ID_W-1:0]    base,
  input  logic [NUM_REQ-1:0] mask,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // Scan base, base+1, ... with explicit modulo wrap; first hit wins.
  always_comb begin
    int pos;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(base) + k) % NUM_REQ;
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/arbiter_round_robin.sv
// rtl/arbiter_round_robin.sv - registered round-robin arbiter with grant hold and burst limit
module arbiter_round_robin
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_W     = id_w(NUM_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [ID_W-1:0]   ID_NONE  = ID_W'(NUM_REQ);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t          state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [ID_W-1:0]     id_nxt;
  logic [NUM_REQ-1:0]  onehot_nxt;
  logic                owner_req;
  logic [NUM_REQ-1:0]  excl_mask;
  logic [ID_W-1:0]     pick_base;
  logic [ID_W-1:0]     all_idx, excl_idx;
  logic                all_found, excl_found;

  // Next index with explicit wrap; NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // While granted, gnt_id is the owner: extract its request and mask it out for timeout picks.
  always_comb begin
    owner_req = 1'b0;
    excl_mask = req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        owner_req    = req[i];
        excl_mask[i] = 1'b0;
      end
    end
  end

  assign pick_base = (state == ARB_IDLE) ? ptr : wrap_inc(gnt_id);

  arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_all (
    .base  (pick_base),
    .mask  (req),
    .idx   (all_idx),
    .found (all_found)
  );

  arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_excl (
    .base  (pick_base),
    .mask  (excl_mask),
    .idx   (excl_idx),
    .found (excl_found)
  );

  // Next-state: acquire from IDLE, then release > timeout > hold, in that priority.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    id_nxt    = gnt_id;
    case (state)
      ARB_IDLE: begin
        id_nxt = ID_NONE;
        if (all_found) begin
          state_nxt = ARB_GRANT;
          id_nxt    = all_idx;
          hold_nxt  = HOLD_W'(1);
          ptr_nxt   = wrap_inc(all_idx);
        end
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          if (all_found) begin
            id_nxt   = all_idx;
            hold_nxt = HOLD_W'(1);
            ptr_nxt  = wrap_inc(all_idx);
          end else begin
            state_nxt = ARB_IDLE;
            id_nxt    = ID_NONE;
            hold_nxt  = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX)) begin
          // Burst exhausted: hand over if anyone else waits, else re-grant without a gap.
          hold_nxt = HOLD_W'(1);
          if (excl_found) begin
            id_nxt  = excl_idx;
            ptr_nxt = wrap_inc(excl_idx);
          end else begin
            ptr_nxt = wrap_inc(gnt_id);
          end
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        id_nxt    = ID_NONE;
        hold_nxt  = '0;
      end
    endcase
  end

  // One-hot view of the next grant; all zeros for the idle code.
  always_comb begin
    onehot_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_nxt == ID_W'(i)) onehot_nxt[i] = 1'b1;
    end
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_id     <= ID_NONE;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hold_cnt   <= hold_nxt;
      gnt_id     <= id_nxt;
      gnt_valid  <= (state_nxt == ARB_GRANT);
      gnt_onehot <= onehot_nxt;
    end
  end

endmodule

// File: tb/tb_arbiter_round_robin.sv
// tb/tb_arbiter_round_robin.sv - scoreboard bench for arbiter_round_robin
module tb_arbiter_round_robin;

  logic       clk = 1'b0;
  logic       rst_v [3];
  logic [3:0] req_v [3];
  logic [2:0] gid   [3];
  logic       gval  [3];
  logic [3:0] goh   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int    sel;
    int    cyc;
    int    exp_id;
    int    exp_hold;
    string tag;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  // dut0: MAX_HOLD=8, dut1: MAX_HOLD=2, dut2: MAX_HOLD=3
  arbiter_round_robin #(.NUM_REQ(4), .ID_W(3), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]),
    .gnt_id(gid[0]), .gnt_valid(gval[0]), .gnt_onehot(goh[0]));
  arbiter_round_robin #(.NUM_REQ(4), .ID_W(3), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]),
    .gnt_id(gid[1]), .gnt_valid(gval[1]), .gnt_onehot(goh[1]));
  arbiter_round_robin #(.NUM_REQ(4), .ID_W(3), .MAX_HOLD(3)) dut3 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]),
    .gnt_id(gid[2]), .gnt_valid(gval[2]), .gnt_onehot(goh[2]));

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: once the edge after issue has passed, pop and compare.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      logic [3:0] exp_oh;
      logic       exp_v;
      int         act_hold;
      mon_e  = sb.pop_front();
      exp_v  = (mon_e.exp_id < 4);
      exp_oh = exp_v ? (4'b0001 << mon_e.exp_id) : 4'b0000;
      checks++;
      if (int'(gid[mon_e.sel]) != mon_e.exp_id) begin
        errors++;
        $display("FAIL %s gnt_id: got %0d want %0d", mon_e.tag, gid[mon_e.sel], mon_e.exp_id);
      end
      checks++;
      if (gval[mon_e.sel] !== exp_v) begin
        errors++;
        $display("FAIL %s gnt_valid: got %0b want %0b", mon_e.tag, gval[mon_e.sel], exp_v);
      end
      checks++;
      if (goh[mon_e.sel] !== exp_oh) begin
        errors++;
        $display("FAIL %s gnt_onehot: got %b want %b", mon_e.tag, goh[mon_e.sel], exp_oh);
      end
      if (mon_e.exp_hold >= 0 && mon_e.sel == 2) begin
        act_hold = int'(dut3.hold_cnt);
        checks++;
        if (act_hold != mon_e.exp_hold) begin
          errors++;
          $display("FAIL %s hold_cnt: got %0d want %0d", mon_e.tag, act_hold, mon_e.exp_hold);
        end
      end
    end
  end

  task automatic step(input int sel, input logic r, input logic [3:0] rq,
                      input int exp_id, input int exp_hold, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_v[sel] = r;
    req_v[sel] = rq;
    e.sel      = sel;
    e.cyc      = cyc;
    e.exp_id   = exp_id;
    e.exp_hold = exp_hold;
    e.tag      = tag;
    sb.push_back(e);
  endtask

  initial begin
    int rot_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int hold_exp [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
    int wait_cnt;

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      req_v[i] = 4'b0000;
    end
    repeat (2) @(posedge clk);

    // Reset held with all requests up, then released.
    step(0, 1'b1, 4'b1111, 4, -1, "reset_hold0");
    step(0, 1'b1, 4'b1111, 4, -1, "reset_hold1");
    step(0, 1'b0, 4'b1111, 0, -1, "reset_release");

    // Single requester 2 for five cycles.
    step(0, 1'b1, 4'b0000, 4, -1, "single_rst");
    for (int i = 0; i < 5; i++) step(0, 1'b0, 4'b0100, 2, -1, "single_hold");
    step(0, 1'b0, 4'b0000, 4, -1, "single_drop");
    step(0, 1'b0, 4'b0000, 4, -1, "single_idle");
    checks++;
    if (dut8.ptr !== 3'd3) begin
      errors++;
      $display("FAIL single_ptr: got %0d want 3", dut8.ptr);
    end

    // Full rotation with burst limit 2.
    for (int i = 0; i < 10; i++) step(1, 1'b0, 4'b1111, rot_exp[i], -1, "rotation");
    step(1, 1'b0, 4'b0000, 4, -1, "rotation_end");

    // Release handoff from owner 1 to 3, then 0.
    step(0, 1'b1, 4'b0000, 4, -1, "handoff_rst");
    step(0, 1'b0, 4'b0010, 1, -1, "handoff_own1");
    step(0, 1'b0, 4'b0010, 1, -1, "handoff_own1b");
    step(0, 1'b0, 4'b1001, 3, -1, "handoff_to3");
    step(0, 1'b0, 4'b1001, 3, -1, "handoff_keep3");
    step(0, 1'b0, 4'b0001, 0, -1, "handoff_to0");
    step(0, 1'b0, 4'b0000, 4, -1, "handoff_idle");

    // Timeout with no competitor: continuous re-grant.
    for (int i = 0; i < 10; i++) step(2, 1'b0, 4'b0001, 0, hold_exp[i], "timeout_solo");
    step(2, 1'b0, 4'b0000, 4, 0, "timeout_end");

    // Reset in the middle of a grant to 2.
    step(0, 1'b1, 4'b0000, 4, -1, "midrst_pre");
    for (int i = 0; i < 3; i++) step(0, 1'b0, 4'b0100, 2, -1, "midrst_own2");
    step(0, 1'b1, 4'b0110, 4, -1, "midrst_pulse");
    step(0, 1'b0, 4'b0110, 1, -1, "midrst_regrant");
    step(0, 1'b0, 4'b0000, 4, -1, "midrst_idle");

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_round_robin.md
Name: arbiter_round_robin

Overview:
- Registered round-robin arbiter that shares one resource among NUM_REQ requesters.
- Uses the same grant-ID encoding as the fixed-priority arbiter: ID = requester index, ID = NUM_REQ means no grant.
- Adds grant hold (ownership persists while the request stays high), an optional burst limit for fairness, and a rotating priority pointer.
- Sits between requester front-ends and the shared-resource mux, which selects on gnt_id.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, $clog2(NUM_REQ+1) = 3: width of gnt_id; must be able to encode NUM_REQ.
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership; 0 = unlimited.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request vector; bit i = requester i.
- gnt_id  out  ID_W  granted requester index; NUM_REQ (= 4) when idle.
- gnt_valid  out  1  high when gnt_id < NUM_REQ.
- gnt_onehot  out  NUM_REQ  one-hot of gnt_id; all zeros when idle.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset values (rst sampled high at an edge):
  - gnt_id = NUM_REQ, gnt_valid = 0, gnt_onehot = 0.
  - state = IDLE, ptr = 0, hold_cnt = 0.
  - Reset mid-grant drops the grant on that edge; no release handshake.
- Outputs: all are registered. No combinational path from req to the outputs.
- ptr: highest-priority candidate index. After any grant to k, ptr = (k+1) mod NUM_REQ.
- pick(base, mask): first set bit of mask, scanning base, base+1, ... mod NUM_REQ.
- Latency: req rising at edge n (IDLE) -> gnt valid after edge n. The first grant is registered one cycle after req is first sampled.
- State IDLE:
  - req == 0 -> stay IDLE, outputs idle.
  - else -> GRANT; owner = pick(ptr, req); hold_cnt = 1; ptr = owner+1.
- State GRANT, owner o, evaluated each edge in this priority order:
  1. req[o] == 0 (release):
     - If other requests exist -> owner = pick(o+1, req), hold_cnt = 1 (back-to-back, no idle bubble).
     - Else -> IDLE, outputs idle on this edge.
  2. MAX_HOLD != 0 and hold_cnt == MAX_HOLD and req[o] == 1 (timeout):
     - If req & ~(1<<o) != 0 -> owner = pick(o+1, req & ~(1<<o)), hold_cnt = 1.
     - Else -> keep o, hold_cnt = 1 (re-grant, no gap).
  3. Otherwise -> keep o; hold_cnt = hold_cnt + 1 (saturates at MAX_HOLD; unused when MAX_HOLD = 0).
- Simultaneous events:
  - Release by o plus a new request from j in the same cycle -> j is eligible immediately via pick(o+1, req).
  - Requests from non-owners never preempt the owner before release or timeout.
- Invariants:
  - Grant goes only to a requester whose req was high at the deciding edge.
  - At most one bit of gnt_onehot is set.
  - gnt_valid == (gnt_id != NUM_REQ).
- Fairness: with all requesters continuously requesting and MAX_HOLD = M, each requester gets M cycles per NUM_REQ*M-cycle round.
- Widths: hold_cnt is $clog2(MAX_HOLD+1) bits (1 bit minimum). ptr and indices are ID_W bits, with the wrap done explicitly (no relying on power-of-two overflow).

Decomposition:
- Package arb_pkg:
  - NUM_REQ_DEF = 4.
  - Function id_w(n) = $clog2(n+1).
  - Constant GNT_NONE = NUM_REQ.
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t.
- Sub-module arb_rr_pick (combinational): inputs base and mask; outputs idx and found. It is a rotated fixed-priority encoder. Instantiate it twice: once for pick(base, req), once for the timeout exclusion mask.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt_id=4, gnt_valid=0, gnt_onehot=0 throughout. Release rst with req=4'b1111 -> gnt_id=0 after the first edge.
- Single requester: req=4'b0100 held 5 cycles (MAX_HOLD=8), then 0 -> gnt_id=2 for 5 cycles, then 4. ptr=3 afterwards.
- Rotation: req=4'b1111 continuously, MAX_HOLD=2 -> gnt_id sequence 0,0,1,1,2,2,3,3,0,0. Consecutive grants have no idle cycle.
- Release handoff: owner 1 holds, req 4'b0010 -> 4'b1001 in one cycle -> next gnt_id=3 (pick from 2 skips 2, finds 3), then 0 after 3 releases.
- Timeout with no competitor: req=4'b0001, MAX_HOLD=3, held 10 cycles -> gnt_id=0 continuously, gnt_valid never drops, hold_cnt wraps 1..3.
- Reset mid-grant: owner 2 in cycle 3 of its grant, rst pulsed 1 cycle with req=4'b0110 -> gnt_id=4 during reset. Next grant goes to 1 (ptr=0 after reset), not 2.
